// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter sharing one physical memory port
// Data port wins unless an instruction request has waited through MAX_D_BURST data grants.
module mem_arbiter #(
   parameter int MAX_D_BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_read,
   input  logic        inst_write,
   input  logic [1:0]  inst_wmask,
   input  logic [15:0] inst_addr,
   input  logic [15:0] inst_wdata,
   output logic [15:0] inst_rdata,
   output logic        inst_resp,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [1:0]  data_wmask,
   input  logic [15:0] data_addr,
   input  logic [15:0] data_wdata,
   output logic [15:0] data_rdata,
   output logic        data_resp,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [1:0]  pmem_wmask,
   output logic [15:0] pmem_address,
   output logic [15:0] pmem_wdata,
   input  logic [15:0] pmem_rdata,
   input  logic        pmem_resp
);

   localparam logic [3:0] LP_MAX_D_BURST = 4'(MAX_D_BURST);

   typedef enum logic [1:0] {S_IDLE, S_SERVE_I, S_SERVE_D} state_t;

   state_t     r_state;
   logic [3:0] r_dcount;
   logic       w_inst_req;
   logic       w_data_req;
   logic       w_grant_d;
   logic [3:0] w_dcount_inc;

   assign w_inst_req   = inst_read | inst_write;
   assign w_data_req   = data_read | data_write;
   assign w_grant_d    = w_data_req & (~w_inst_req | (r_dcount < LP_MAX_D_BURST));
   assign w_dcount_inc = (r_dcount == 4'hF) ? 4'hF : r_dcount + 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_dcount     <= 4'd0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_wmask   <= 2'b00;
         pmem_address <= 16'h0000;
         pmem_wdata   <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_d) begin
                  r_state      <= S_SERVE_D;
                  r_dcount     <= w_inst_req ? w_dcount_inc : 4'd0;
                  pmem_write   <= data_write;
                  pmem_read    <= data_read & ~data_write;
                  pmem_wmask   <= data_wmask;
                  pmem_address <= data_addr;
                  pmem_wdata   <= data_wdata;
               end else if (w_inst_req) begin
                  r_state      <= S_SERVE_I;
                  r_dcount     <= 4'd0;
                  pmem_write   <= inst_write;
                  pmem_read    <= inst_read & ~inst_write;
                  pmem_wmask   <= inst_wmask;
                  pmem_address <= inst_addr;
                  pmem_wdata   <= inst_wdata;
               end
            end
            S_SERVE_I, S_SERVE_D: begin
               // address and write data are left in place after completion
               if (pmem_resp) begin
                  r_state    <= S_IDLE;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
                  pmem_wmask <= 2'b00;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign inst_resp  = (r_state == S_SERVE_I) & pmem_resp;
   assign data_resp  = (r_state == S_SERVE_D) & pmem_resp;
   assign inst_rdata = pmem_rdata;
   assign data_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Bench plays both requesters and the memory; MAX_D_BURST is 2 for the starvation sequence.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        inst_read, inst_write;
   logic [1:0]  inst_wmask;
   logic [15:0] inst_addr, inst_wdata, inst_rdata;
   logic        inst_resp;
   logic        data_read, data_write;
   logic [1:0]  data_wmask;
   logic [15:0] data_addr, data_wdata, data_rdata;
   logic        data_resp;
   logic        pmem_read, pmem_write;
   logic [1:0]  pmem_wmask;
   logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
   logic        pmem_resp;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter #(.MAX_D_BURST(2)) dut (
      .clk(clk), .reset(reset),
      .inst_read(inst_read), .inst_write(inst_write), .inst_wmask(inst_wmask),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_resp(inst_resp),
      .data_read(data_read), .data_write(data_write), .data_wmask(data_wmask),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_resp(data_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, pmem_wmask} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {pmem_read, pmem_write, pmem_wmask});
      end
      n_tests++;
      if ({pmem_address, pmem_wdata} !== 32'h0) begin
         n_fail++; $display("FAIL reset_addr_data: got %h expected 00000000", {pmem_address, pmem_wdata});
      end
      n_tests++;
      if ({inst_resp, data_resp} !== 2'b00) begin
         n_fail++; $display("FAIL reset_resp: got %b expected 00", {inst_resp, data_resp});
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_idle_resp();
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if ({inst_resp, data_resp} !== 2'b00) begin
         n_fail++; $display("FAIL idle_resp: got %b expected 00", {inst_resp, data_resp});
      end
      tick();
      pmem_resp = 1'b0;
      n_tests++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
         n_fail++; $display("FAIL idle_resp_strobes: got %b expected 00", {pmem_read, pmem_write});
      end
   endtask

   task automatic test_single_fetch();
      inst_read = 1'b1;
      inst_addr = 16'h0040;
      tick();
      for (int c = 0; c < 3; c++) begin
         n_tests++;
         if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h0040}) begin
            n_fail++; $display("FAIL fetch_issue[%0d]: got r%b w%b a%h expected r1 w0 a0040", c, pmem_read, pmem_write, pmem_address);
         end
         n_tests++;
         if (inst_resp !== 1'b0) begin
            n_fail++; $display("FAIL fetch_early_resp[%0d]: got %b expected 0", c, inst_resp);
         end
         if (c < 2) tick();
      end
      pmem_resp  = 1'b1;
      pmem_rdata = 16'h1234;
      #1;
      n_tests++;
      if ({inst_resp, data_resp, inst_rdata} !== {2'b10, 16'h1234}) begin
         n_fail++; $display("FAIL fetch_resp: got i%b d%b rd%h expected i1 d0 rd1234", inst_resp, data_resp, inst_rdata);
      end
      inst_read = 1'b0;
      tick();
      pmem_resp = 1'b0;
      #1;
      n_tests++;
      if ({inst_resp, pmem_read, pmem_wmask, pmem_address} !== {4'b0000, 16'h0040}) begin
         n_fail++; $display("FAIL fetch_after: got resp%b r%b m%b a%h expected resp0 r0 m00 a0040", inst_resp, pmem_read, pmem_wmask, pmem_address);
      end
   endtask

   task automatic test_simultaneous();
      inst_read  = 1'b1; inst_addr  = 16'h0100;
      data_write = 1'b1; data_addr  = 16'h2000; data_wdata = 16'hBEEF; data_wmask = 2'b10;
      tick();
      n_tests++;
      if ({pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata} !== {4'b0110, 16'h2000, 16'hBEEF}) begin
         n_fail++; $display("FAIL simul_data_first: got r%b w%b m%b a%h wd%h expected r0 w1 m10 a2000 wdBEEF", pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata);
      end
      tick();
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if ({inst_resp, data_resp} !== 2'b01) begin
         n_fail++; $display("FAIL simul_data_resp: got i%b d%b expected i0 d1", inst_resp, data_resp);
      end
      data_write = 1'b0;
      tick();
      pmem_resp = 1'b0;
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, inst_resp} !== 3'b000) begin
         n_fail++; $display("FAIL simul_idle_gap: got r%b w%b iresp%b expected 000", pmem_read, pmem_write, inst_resp);
      end
      tick();
      n_tests++;
      if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h0100}) begin
         n_fail++; $display("FAIL simul_inst_issue: got r%b w%b a%h expected r1 w0 a0100", pmem_read, pmem_write, pmem_address);
      end
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if ({inst_resp, data_resp} !== 2'b10) begin
         n_fail++; $display("FAIL simul_inst_resp: got i%b d%b expected i1 d0", inst_resp, data_resp);
      end
      inst_read = 1'b0;
      tick();
      pmem_resp = 1'b0;
   endtask

   task automatic test_rw_both();
      data_read = 1'b1; data_write = 1'b1; data_addr = 16'h3000; data_wmask = 2'b11;
      tick();
      n_tests++;
      if ({pmem_read, pmem_write, pmem_address} !== {2'b01, 16'h3000}) begin
         n_fail++; $display("FAIL rw_both: got r%b w%b a%h expected r0 w1 a3000", pmem_read, pmem_write, pmem_address);
      end
      pmem_resp = 1'b1;
      #1;
      data_read = 1'b0; data_write = 1'b0;
      tick();
      pmem_resp = 1'b0;
   endtask

   task automatic test_input_change();
      data_read = 1'b1; data_addr = 16'h4000;
      tick();
      data_addr = 16'h5000;
      tick();
      n_tests++;
      if (pmem_address !== 16'h4000) begin
         n_fail++; $display("FAIL hold_addr: got %h expected 4000", pmem_address);
      end
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if ({data_resp, pmem_address} !== {1'b1, 16'h4000}) begin
         n_fail++; $display("FAIL hold_addr_resp: got resp%b a%h expected resp1 a4000", data_resp, pmem_address);
      end
      data_read = 1'b0;
      tick();
      pmem_resp = 1'b0;
   endtask

   task automatic test_starvation();
      logic [5:0] exp_d;
      exp_d = 6'b011011;
      inst_read = 1'b1; inst_addr = 16'h0100;
      data_read = 1'b1; data_addr = 16'h6000;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_tests++;
         if (pmem_address !== (exp_d[k] ? 16'h6000 : 16'h0100)) begin
            n_fail++; $display("FAIL burst_grant[%0d]: got a%h expected %s", k, pmem_address, exp_d[k] ? "6000" : "0100");
         end
         pmem_resp = 1'b1;
         #1;
         n_tests++;
         if ({inst_resp, data_resp} !== {~exp_d[k], exp_d[k]}) begin
            n_fail++; $display("FAIL burst_resp[%0d]: got i%b d%b expected i%b d%b", k, inst_resp, data_resp, ~exp_d[k], exp_d[k]);
         end
         if (k == 5) begin
            inst_read = 1'b0; data_read = 1'b0;
         end
         tick();
         pmem_resp = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      inst_read = 1'b1; inst_addr = 16'h0200;
      tick();
      n_tests++;
      if (pmem_read !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_issue: got %b expected 1", pmem_read);
      end
      #2;
      reset = 1'b1;
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, pmem_wmask, inst_resp} !== 5'b00000) begin
         n_fail++; $display("FAIL rst_mid_drop: got r%b w%b m%b iresp%b expected 00000", pmem_read, pmem_write, pmem_wmask, inst_resp);
      end
      #2;
      reset = 1'b0;
      pmem_resp = 1'b0;
      #1;
      n_tests++;
      if (pmem_read !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_idle: got %b expected 0", pmem_read);
      end
      tick();
      n_tests++;
      if ({pmem_read, pmem_address} !== {1'b1, 16'h0200}) begin
         n_fail++; $display("FAIL rst_mid_regrant: got r%b a%h expected r1 a0200", pmem_read, pmem_address);
      end
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if (inst_resp !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_resp: got %b expected 1", inst_resp);
      end
      inst_read = 1'b0;
      tick();
      pmem_resp = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      inst_read = 1'b0; inst_write = 1'b0; inst_wmask = 2'b00; inst_addr = 16'h0; inst_wdata = 16'h0;
      data_read = 1'b0; data_write = 1'b0; data_wmask = 2'b00; data_addr = 16'h0; data_wdata = 16'h0;
      pmem_rdata = 16'h0; pmem_resp = 1'b0;
      test_reset();
      test_idle_resp();
      test_single_fetch();
      test_simultaneous();
      test_rw_both();
      test_input_change();
      test_starvation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
